// File: rtl/cnn_window_gen_pkg.sv
// Shared window geometry for the window generator and the conv kernel.
// Both sides pack window element (ky,kx) at flat index ky*KX+kx.
package cnn_window_gen_pkg;

    localparam int KX_DEF       = 3;
    localparam int KY_DEF       = 3;
    localparam int DATA_LEN_DEF = 8;
    localparam int IX_DEF       = 28;
    localparam int IY_DEF       = 28;

    function automatic int win_idx(input int ky, input int kx, input int kx_n);
        return ky * kx_n + kx;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One feature-map row of delay: DEPTH-deep shift line with enable.
// o_data is the pixel accepted DEPTH enables ago; contents are never cleared.
module cnn_line_buffer
    import cnn_window_gen_pkg::*;
#(
    parameter int DEPTH    = IX_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic                clk,
    input  logic                i_en,
    input  logic [DATA_LEN-1:0] i_data,
    output logic [DATA_LEN-1:0] o_data
);

    logic [DATA_LEN-1:0] mem_q [DEPTH];
    logic [DATA_LEN-1:0] mem_d [DEPTH];

    // shift one slot per accepted pixel, hold otherwise
    always_comb begin
        mem_d = mem_q;
        if (i_en) begin
            mem_d[0] = i_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // storage register, deliberately without reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_data = mem_q[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// Sliding KX x KY window generator, stride 1, no padding.
// Emits one flattened window per accepted pixel once a full window exists.
module cnn_window_gen
    import cnn_window_gen_pkg::*;
#(
    parameter int KX       = KX_DEF,
    parameter int KY       = KY_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int IX       = IX_DEF,
    parameter int IY       = IY_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_soft_reset,
    input  logic                        i_in_valid,
    input  logic [DATA_LEN-1:0]         i_in_pixel,
    output logic                        o_ot_valid,
    output logic [KX*KY*DATA_LEN-1:0]   o_ot_fmap,
    output logic                        o_ot_frame_done
);

    localparam int CW = (IX > 1) ? $clog2(IX) : 1;
    localparam int RW = (IY > 1) ? $clog2(IY) : 1;
    localparam int NL = KY - 1;
    localparam int FW = KX * KY * DATA_LEN;

    logic          accept;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [FW-1:0] fmap_q, fmap_d;

    logic [DATA_LEN-1:0] win_q [KY][KX];
    logic [DATA_LEN-1:0] win_d [KY][KX];
    logic [DATA_LEN-1:0] lb_in  [NL];
    logic [DATA_LEN-1:0] lb_out [NL];

    assign accept = i_in_valid && !i_soft_reset;

    // chain the line buffers: newest row feeds buffer 0
    always_comb begin
        lb_in[0] = i_in_pixel;
        for (int l = 1; l < NL; l++) begin
            lb_in[l] = lb_out[l-1];
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_lb
        cnn_line_buffer #(
            .DEPTH    (IX),
            .DATA_LEN (DATA_LEN)
        ) u_lb (
            .clk    (clk),
            .i_en   (accept),
            .i_data (lb_in[g]),
            .o_data (lb_out[g])
        );
    end

    // window shifts left; new right column comes from the row delays
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX - 1; kx++) begin
                    win_d[ky][kx] = win_q[ky][kx+1];
                end
            end
            for (int ky = 0; ky < KY - 1; ky++) begin
                win_d[ky][KX-1] = lb_out[KY-2-ky];
            end
            win_d[KY-1][KX-1] = i_in_pixel;
        end
    end

    // raster position, valid/done strobes and the held output window
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        fmap_d  = fmap_q;
        if (i_soft_reset) begin
            col_d  = '0;
            row_d  = '0;
            fmap_d = '0;
        end else if (accept) begin
            valid_d = (row_q >= RW'(KY - 1)) && (col_q >= CW'(KX - 1));
            done_d  = (row_q == RW'(IY - 1)) && (col_q == CW'(IX - 1));
            if (col_q == CW'(IX - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IY - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (valid_d) begin
                for (int ky = 0; ky < KY; ky++) begin
                    for (int kx = 0; kx < KX; kx++) begin
                        fmap_d[win_idx(ky, kx, KX)*DATA_LEN +: DATA_LEN] = win_d[ky][kx];
                    end
                end
            end
        end
    end

    // control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            fmap_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            fmap_q  <= fmap_d;
        end
    end

    // window storage, deliberately without reset
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign o_ot_valid      = valid_q;
    assign o_ot_fmap       = fmap_q;
    assign o_ot_frame_done = done_q;

endmodule
